gen_wr_arbiter: RTL and testbench

Round-robin write arbiter sharing one FIFO write port between two pseudo-random word generators. Each generator sees its own per-requester full (its normal backpressure input) and asserts wrreq with a data word. The arbiter grants one requester at a time for bursts of up to BURST words and forwards the granted write to the FIFO with zero latency. It sits between the generators and the FIFO that feeds the 7-segment display path.

---
 rtl/gen_wr_arbiter.sv | 189 ++++++++++++++++++
 tb/tb_gen_wr_arbiter.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/gen_wr_arbiter.sv
// gen_wr_arbiter: round-robin burst arbiter that shares one FIFO write port between two word generators.
// Optional build macro ARB_STATS_EN adds per-requester accepted-word counters (req_cnt0/req_cnt1).
module gen_wr_arbiter #(
  parameter int DW    = 8,
  parameter int BURST = 4,
  parameter int CW    = 16
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          wrreq0,
  input  logic [DW:1]   data0,
  output logic          full0,
  input  logic          wrreq1,
  input  logic [DW:1]   data1,
  output logic          full1,
  input  logic          fifo_full,
  output logic          fifo_wrreq,
  output logic [DW:1]   fifo_data,
  output logic [1:0]    gnt,
  output logic [CW-1:0] words_cnt,
  output logic [CW-1:0] req_cnt0,
  output logic [CW-1:0] req_cnt1
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  localparam logic [7:0] BURST_LAST = 8'(BURST - 1);

  state_t        state_r;
  state_t        state_next_s;
  state_t        own_state_s;
  state_t        other_state_s;
  logic [1:0]    gnt_r;
  logic          last_r;
  logic          last_next_s;
  logic [7:0]    burst_cnt_r;
  logic [7:0]    burst_cnt_next_s;
  logic [CW-1:0] words_cnt_r;
  logic          is_gnt1_s;
  logic          own_req_s;
  logic          other_req_s;
  logic          full0_s;
  logic          full1_s;
  logic          acc0_s;
  logic          acc1_s;
  logic          fifo_wrreq_s;
  logic [DW:1]   fifo_data_s;

  function automatic logic [1:0] gnt_decode(input state_t s);
    case (s)
      GNT0:    gnt_decode = 2'b01;
      GNT1:    gnt_decode = 2'b10;
      default: gnt_decode = 2'b00;
    endcase
  endfunction

  // Granted/other requester views, so both grant states share one transition rule
  assign is_gnt1_s     = (state_r == GNT1);
  assign own_req_s     = is_gnt1_s ? wrreq1 : wrreq0;
  assign other_req_s   = is_gnt1_s ? wrreq0 : wrreq1;
  assign own_state_s   = is_gnt1_s ? GNT1 : GNT0;
  assign other_state_s = is_gnt1_s ? GNT0 : GNT1;

  // State register; gnt is registered from the next state so it always matches state_r
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r     <= IDLE;
      gnt_r       <= 2'b00;
      last_r      <= 1'b1;
      burst_cnt_r <= 8'd0;
    end else begin
      state_r     <= state_next_s;
      gnt_r       <= gnt_decode(state_next_s);
      last_r      <= last_next_s;
      burst_cnt_r <= burst_cnt_next_s;
    end
  end

  // Next-state logic: round-robin from IDLE, burst counting and release while granted
  always_comb begin
    state_next_s     = state_r;
    last_next_s      = last_r;
    burst_cnt_next_s = burst_cnt_r;
    case (state_r)
      IDLE: begin
        if (wrreq0 && wrreq1) begin
          state_next_s = last_r ? GNT0 : GNT1;
        end else if (wrreq0) begin
          state_next_s = GNT0;
        end else if (wrreq1) begin
          state_next_s = GNT1;
        end else begin
          state_next_s = IDLE;
        end
      end
      GNT0, GNT1: begin
        if (!own_req_s) begin
          burst_cnt_next_s = 8'd0;
          last_next_s      = is_gnt1_s;
          state_next_s     = other_req_s ? other_state_s : IDLE;
        end else if (fifo_full) begin
          // Stalled: no switching, burst position frozen
          burst_cnt_next_s = burst_cnt_r;
          state_next_s     = state_r;
        end else if (burst_cnt_r == BURST_LAST) begin
          burst_cnt_next_s = 8'd0;
          last_next_s      = is_gnt1_s;
          state_next_s     = other_req_s ? other_state_s : own_state_s;
        end else begin
          burst_cnt_next_s = burst_cnt_r + 8'd1;
          state_next_s     = state_r;
        end
      end
      default: begin
        state_next_s     = IDLE;
        burst_cnt_next_s = 8'd0;
      end
    endcase
  end

  // Output logic: zero-latency forwarding of the granted requester to the FIFO
  always_comb begin
    full0_s      = fifo_full | ~gnt_r[0];
    full1_s      = fifo_full | ~gnt_r[1];
    acc0_s       = wrreq0 & ~full0_s;
    acc1_s       = wrreq1 & ~full1_s;
    fifo_wrreq_s = 1'b0;
    fifo_data_s  = {DW{1'b0}};
    case (gnt_r)
      2'b01: begin
        fifo_wrreq_s = wrreq0 & ~fifo_full;
        fifo_data_s  = data0;
      end
      2'b10: begin
        fifo_wrreq_s = wrreq1 & ~fifo_full;
        fifo_data_s  = data1;
      end
      default: begin
        fifo_wrreq_s = 1'b0;
        fifo_data_s  = {DW{1'b0}};
      end
    endcase
  end

  // Total accepted-word counter, wraps modulo 2^CW
  always_ff @(posedge CLK) begin
    if (RST) begin
      words_cnt_r <= {CW{1'b0}};
    end else if (acc0_s || acc1_s) begin
      words_cnt_r <= words_cnt_r + CW'(1'b1);
    end else begin
      words_cnt_r <= words_cnt_r;
    end
  end

`ifdef ARB_STATS_EN
  logic [CW-1:0] req_cnt0_r;
  logic [CW-1:0] req_cnt1_r;

  // Per-requester accepted-word counters
  always_ff @(posedge CLK) begin
    if (RST) begin
      req_cnt0_r <= {CW{1'b0}};
      req_cnt1_r <= {CW{1'b0}};
    end else begin
      req_cnt0_r <= acc0_s ? (req_cnt0_r + CW'(1'b1)) : req_cnt0_r;
      req_cnt1_r <= acc1_s ? (req_cnt1_r + CW'(1'b1)) : req_cnt1_r;
    end
  end

  assign req_cnt0 = req_cnt0_r;
  assign req_cnt1 = req_cnt1_r;
`else
  assign req_cnt0 = {CW{1'b0}};
  assign req_cnt1 = {CW{1'b0}};
`endif

  assign full0      = full0_s;
  assign full1      = full1_s;
  assign fifo_wrreq = fifo_wrreq_s;
  assign fifo_data  = fifo_data_s;
  assign gnt        = gnt_r;
  assign words_cnt  = words_cnt_r;

endmodule

// File: tb/tb_gen_wr_arbiter.sv
// Directed bench for gen_wr_arbiter (BURST=4, CW=4 so words_cnt wraps after 16 accepts);
// expected FIFO words are queued as stimulus is planned and popped on each observed write.
module tb_gen_wr_arbiter;
  localparam int DW = 8;
  localparam int CW = 4;

  logic          CLK = 1'b0;
  logic          RST;
  logic          wrreq0, wrreq1, fifo_full;
  logic [DW:1]   data0, data1;
  logic          full0, full1, fifo_wrreq;
  logic [DW:1]   fifo_data;
  logic [1:0]    gnt;
  logic [CW-1:0] words_cnt, req_cnt0, req_cnt1;

  int n_vec = 0;
  int n_err = 0;
  int n_wr  = 0;
  logic [8:0] exp_q[$];

  gen_wr_arbiter #(.DW(DW), .BURST(4), .CW(CW)) dut (
    .CLK(CLK), .RST(RST),
    .wrreq0(wrreq0), .data0(data0), .full0(full0),
    .wrreq1(wrreq1), .data1(data1), .full1(full1),
    .fifo_full(fifo_full), .fifo_wrreq(fifo_wrreq), .fifo_data(fifo_data),
    .gnt(gnt), .words_cnt(words_cnt), .req_cnt0(req_cnt0), .req_cnt1(req_cnt1)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: check any FIFO write at the negedge, then advance the generators on accept.
  task automatic tick();
    logic       acc0, acc1;
    logic [8:0] exp_w;
    @(negedge CLK);
    if (!RST && fifo_wrreq) begin
      n_wr++;
      exp_w = (exp_q.size() != 0) ? exp_q.pop_front() : 9'h1FF;
      chk("wdata", {24'd0, fifo_data}, {23'd0, exp_w});
    end
    acc0 = !RST && wrreq0 && !full0;
    acc1 = !RST && wrreq1 && !full1;
    @(posedge CLK);
    #1;
    if (acc0) data0 = data0 + 8'd1;
    if (acc1) data1 = data1 + 8'd1;
  endtask

  task automatic push_seq(input logic [7:0] first, input int n);
    for (int k = 0; k < n; k++) exp_q.push_back({1'b0, first + 8'(k)});
  endtask

  task automatic chk_stats(input string tag, input logic [31:0] e0, input logic [31:0] e1);
`ifdef ARB_STATS_EN
    chk({tag, "_req0"}, req_cnt0, e0);
    chk({tag, "_req1"}, req_cnt1, e1);
`else
    chk({tag, "_req0"}, req_cnt0, 32'd0);
    chk({tag, "_req1"}, req_cnt1, 32'd0);
`endif
  endtask

  initial begin
    RST = 1'b1; wrreq0 = 1'b1; wrreq1 = 1'b1; fifo_full = 1'b0;
    data0 = 8'h01; data1 = 8'h81;
    tick(); tick();
    chk("rst_gnt", gnt, 32'd0);
    chk("rst_wr", fifo_wrreq, 32'd0);
    chk("rst_full0", full0, 32'd1);
    chk("rst_full1", full1, 32'd1);
    chk("rst_words", words_cnt, 32'd0);

    // Alternation: both active, 4-word bursts, no bubble at switches
    RST = 1'b0;
    push_seq(8'h01, 4); push_seq(8'h81, 4); push_seq(8'h05, 4); push_seq(8'h85, 4);
    tick();
    chk("first_gnt", gnt, 32'd1);
    n_wr = 0;
    for (int i = 0; i < 16; i++) tick();
    chk("alt_writes", n_wr, 32'd16);
    chk("alt_words_wrap", words_cnt, 32'd0);
    chk_stats("alt", 32'd8, 32'd8);
    chk("alt_q_empty", exp_q.size(), 32'd0);

    // Reset mid-burst
    push_seq(8'h09, 2);
    tick(); tick();
    chk("mid_words", words_cnt, 32'd2);
    RST = 1'b1; wrreq1 = 1'b0;
    tick();
    chk("mrst_gnt", gnt, 32'd0);
    chk("mrst_words", words_cnt, 32'd0);
    chk_stats("mrst", 32'd0, 32'd0);
    chk("mrst_wr", fifo_wrreq, 32'd0);
    chk("mrst_full0", full0, 32'd1);

    // Single requester across burst boundaries
    RST = 1'b0; data0 = 8'h01; data1 = 8'h81;
    push_seq(8'h01, 10);
    tick();
    n_wr = 0;
    for (int i = 0; i < 10; i++) tick();
    chk("single_writes", n_wr, 32'd10);
    chk("single_gnt", gnt, 32'd1);
    chk("single_words", words_cnt, 32'd10);
    chk_stats("single", 32'd10, 32'd0);

    // Stall after 2 accepts into the current burst
    wrreq1 = 1'b1; fifo_full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_wr", fifo_wrreq, 32'd0);
      chk("stall_full0", full0, 32'd1);
      chk("stall_full1", full1, 32'd1);
      chk("stall_gnt", gnt, 32'd1);
    end
    fifo_full = 1'b0;
    push_seq(8'h0B, 2); push_seq(8'h81, 4);
    tick(); tick();
    chk("stall_switch_gnt", gnt, 32'd2);
    for (int i = 0; i < 4; i++) tick();
    chk("back_gnt", gnt, 32'd1);
    chk("wrap_words", words_cnt, 32'd0);
    chk_stats("stall", 32'd12, 32'd4);
    chk("stall_q_empty", exp_q.size(), 32'd0);

    // Early release by requester 0 after one word
    push_seq(8'h0D, 1);
    tick();
    wrreq0 = 1'b0;
    tick();
    chk("early_gnt", gnt, 32'd2);
    chk("early_full0", full0, 32'd1);
    push_seq(8'h85, 4);
    n_wr = 0;
    for (int i = 0; i < 4; i++) tick();
    chk("early_burst", n_wr, 32'd4);
    chk("early_gnt_hold", gnt, 32'd2);
    wrreq1 = 1'b0;
    tick();
    chk("idle_gnt", gnt, 32'd0);
    chk("final_words", words_cnt, 32'd5);
    chk("final_q_empty", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
